// File: rtl/prog_launch_ctrl_pkg.sv
// rtl/prog_launch_ctrl_pkg.sv - shared types for the program launch controller
package pc_ctrl_pkg;

    localparam int PC_W = 10;

    typedef enum logic [2:0] {IDLE, LAUNCH, ARM, RUN, DONE} launch_st_t;

    typedef enum logic [1:0] {
        ST_OK  = 2'b00,
        ST_TMO = 2'b01,
        ST_ABT = 2'b10
    } run_status_t;

    // States in which a program is in flight and may be cancelled.
    function automatic logic is_abortable(input launch_st_t st);
        return (st == LAUNCH) || (st == ARM) || (st == RUN);
    endfunction

endpackage

// File: rtl/prog_launch_ctrl_if.sv
// rtl/prog_launch_ctrl_if.sv - host/ProgCtr-side signal bundle of the launch controller
interface prog_launch_ctrl_if #(
    parameter int SEL_W = 2,
    parameter int CNT_W = 16
) ();
    logic             Req;
    logic [SEL_W-1:0] ReqSel;
    logic             Done;
    logic             Abort;
    logic             PcStart;
    logic [SEL_W-1:0] ProgSel;
    logic             Busy;
    logic             Ack;
    logic [1:0]       Status;
    logic [CNT_W-1:0] CycleCnt;
    logic             ReqDrop;

    modport master (
        output Req, ReqSel, Done, Abort,
        input  PcStart, ProgSel, Busy, Ack, Status, CycleCnt, ReqDrop
    );

    modport slave (
        input  Req, ReqSel, Done, Abort,
        output PcStart, ProgSel, Busy, Ack, Status, CycleCnt, ReqDrop
    );
endinterface

// File: rtl/prog_launch_ctrl_slot.sv
// rtl/prog_launch_ctrl_slot.sv - one-deep pending request register with drop pulse
module launch_req_slot #(
    parameter int SEL_W = 2
) (
    input  logic             clk_i,
    input  logic             resetn_i,
    input  logic             push_i,
    input  logic [SEL_W-1:0] sel_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic [SEL_W-1:0] sel_o,
    output logic             drop_o
);
    logic             full_q;
    logic [SEL_W-1:0] sel_q;
    logic             drop_q;

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            full_q <= 1'b0;
            sel_q  <= '0;
            drop_q <= 1'b0;
        end else begin
            // A pop in the same cycle frees the slot, so the new push is accepted.
            drop_q <= push_i && full_q && !pop_i;
            if (push_i && (!full_q || pop_i)) begin
                full_q <= 1'b1;
                sel_q  <= sel_i;
            end else if (pop_i) begin
                full_q <= 1'b0;
            end
        end
    end

    assign full_o = full_q;
    assign sel_o  = sel_q;
    assign drop_o = drop_q;
endmodule

// File: rtl/prog_launch_ctrl.sv
// rtl/prog_launch_ctrl.sv - ProgCtr Start sequencer with watchdog, abort and pending slot
module prog_launch_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int START_CYC = 2,
    parameter int MAX_CYC   = 1023,
    parameter int CNT_W     = 16,
    parameter int SEL_W     = 2
) (
    input  logic               Clk,
    input  logic               Reset_n,
    prog_launch_ctrl_if.slave  bus
);
    localparam int HOLD_W = (START_CYC > 1) ? $clog2(START_CYC) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(START_CYC - 1);

    launch_st_t        state_q;
    run_status_t       status_q;
    logic              pc_start_q;
    logic              busy_q;
    logic              ack_q;
    logic [SEL_W-1:0]  prog_sel_q;
    logic [CNT_W-1:0]  cycle_cnt_q;
    logic [HOLD_W-1:0] hold_cnt_q;

    logic              slot_full;
    logic [SEL_W-1:0]  slot_sel;
    logic              slot_drop;
    logic              slot_push;
    logic              slot_pop;
    logic              abort_go;
    logic [CNT_W-1:0]  cnt_inc;

    // An IDLE request with an occupied slot is queued behind the pending one.
    assign slot_pop  = (state_q == IDLE) && slot_full;
    assign slot_push = bus.Req && ((state_q != IDLE) || slot_full);
    assign abort_go  = bus.Abort && is_abortable(state_q);
    assign cnt_inc   = (cycle_cnt_q == '1) ? cycle_cnt_q : cycle_cnt_q + 1'b1;

    launch_req_slot #(.SEL_W(SEL_W)) u_slot (
        .clk_i    (Clk),
        .resetn_i (Reset_n),
        .push_i   (slot_push),
        .sel_i    (bus.ReqSel),
        .pop_i    (slot_pop),
        .full_o   (slot_full),
        .sel_o    (slot_sel),
        .drop_o   (slot_drop)
    );

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q     <= IDLE;
            status_q    <= ST_OK;
            pc_start_q  <= 1'b0;
            busy_q      <= 1'b0;
            ack_q       <= 1'b0;
            prog_sel_q  <= '0;
            cycle_cnt_q <= '0;
            hold_cnt_q  <= '0;
        end else begin
            ack_q <= 1'b0;
            if (abort_go) begin
                state_q    <= DONE;
                status_q   <= ST_ABT;
                ack_q      <= 1'b1;
                pc_start_q <= 1'b0;
                if (state_q == ARM) cycle_cnt_q <= '0;
                if (state_q == RUN) cycle_cnt_q <= cnt_inc;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (slot_full || bus.Req) begin
                            state_q    <= LAUNCH;
                            pc_start_q <= 1'b1;
                            busy_q     <= 1'b1;
                            hold_cnt_q <= '0;
                            prog_sel_q <= slot_full ? slot_sel : bus.ReqSel;
                        end
                    end
                    LAUNCH: begin
                        if (hold_cnt_q == HOLD_LAST) begin
                            state_q    <= ARM;
                            pc_start_q <= 1'b0;
                        end else begin
                            hold_cnt_q <= hold_cnt_q + 1'b1;
                        end
                    end
                    ARM: begin
                        cycle_cnt_q <= '0;
                        state_q     <= RUN;
                    end
                    RUN: begin
                        cycle_cnt_q <= cnt_inc;
                        if (bus.Done) begin
                            state_q  <= DONE;
                            status_q <= ST_OK;
                            ack_q    <= 1'b1;
                        end else if (cnt_inc == CNT_W'(MAX_CYC)) begin
                            state_q  <= DONE;
                            status_q <= ST_TMO;
                            ack_q    <= 1'b1;
                        end
                    end
                    DONE: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.PcStart  = pc_start_q;
    assign bus.ProgSel  = prog_sel_q;
    assign bus.Busy     = busy_q;
    assign bus.Ack      = ack_q;
    assign bus.Status   = status_q;
    assign bus.CycleCnt = cycle_cnt_q;
    assign bus.ReqDrop  = slot_drop;
endmodule
